ntt_seq_ctrl: RTL and testbench
===============================

// Module: ntt_seq_ctrl
// PURPOSE
//  Sequencer directly upstream of the butterfly. Walks all 7 Kyber NTT/INTT layers over a 256-coeff bank.
//  Each cycle it issues two coefficient RAM reads plus a twiddle-ROM index and drives the butterfly mode.
//  A delay line matched to RAM + butterfly latency produces the RAM write-back addresses for c/d.
//  One butterfly per cycle; pipeline drained between layers to avoid RAW hazards.
// PARAMETERS
//  RAM_LAT  1  cycles from rd_en/rd_addr to RAM data (and twiddle ROM data) valid
//  BF_LAT   5  cycles from butterfly a/b/w valid to c/d valid
//  (D = RAM_LAT + BF_LAT, total issue-to-write delay)
// PORTS
//  clk         in   1  single clock, rising edge
//  rst         in   1  synchronous, active-high reset
//  start       in   1  one-cycle request, sampled only in IDLE
//  inv         in   1  0 = forward NTT, 1 = INTT; latched on accepted start
//  busy        out  1  high from cycle after accepted start until done
//  done        out  1  one-cycle pulse after final write-back
//  rd_en       out  1  RAM read strobe (both ports)
//  rd_addr_a   out  8  RAM port A read address (j)
//  rd_addr_b   out  8  RAM port B read address (j+len)
//  tw_idx      out  7  twiddle ROM index k, same cycle as rd_en
//  bf_mode     out  2  butterfly mode: 00 NTT, 01 INTT, 11 idle
//  wr_en       out  1  RAM write strobe for butterfly c/d
//  wr_addr_c   out  8  write address for c (delayed rd_addr_a)
//  wr_addr_d   out  8  write address for d (delayed rd_addr_b)
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, rd_en=0, wr_en=0, all addrs/tw_idx=0, bf_mode=11; delay line cleared.
//  FSM: IDLE -(start)-> ISSUE -(bf==127)-> DRAIN -(D cycles, layer<6)-> ISSUE; DRAIN (layer==6) -> DONE -> IDLE.
//  Layer lg = log2(len): NTT lg 7..1 (len 128..2); INTT lg 1..7 (len 2..128). 3-bit layer counter 0..6.
//  ISSUE: 7-bit bf counter i, 0..127, one per cycle, rd_en=1.
//   block = i>>lg; off = i & (len-1); j = block*2*len + off; rd_addr_a=j, rd_addr_b=j+len (8-bit, never wraps).
//   NTT: tw_idx = 2^(7-lg) + block (1..127, increasing). INTT: tw_idx = 2^(8-lg) - 1 - block (127..1, decreasing).
//  All issue outputs registered. First rd_en is the cycle after start is accepted.
//  Write-back: wr_en/wr_addr_c/wr_addr_d = rd_en/rd_addr_a/rd_addr_b delayed exactly D cycles.
//  DRAIN: rd_en=0 for D cycles; the next layer's first read comes the cycle after the previous layer's last write.
//  bf_mode = {1'b0,inv_q} from start accept through final write; 11 only in IDLE/DONE.
//  done pulses in the cycle after the last wr_en; busy drops in that same cycle.
//  Start-to-done: 7*(128+D)+1 cycles (939 at defaults).
//  start while busy: ignored, no effect on inv_q. start together with rst: rst wins.
//  rst mid-operation: immediate return to reset values; in-flight writes discarded (wr_en=0 next cycle).
// STRUCTURE
//  ntt_pkg: N=256, ADDR_W=8, TW_W=7, NLAYER=7, mode encodings (MODE_NTT=2'b00, MODE_INTT=2'b01, MODE_IDLE=2'b11),
//  FSM state enum.
//  Sub-module ntt_delay_line #(W, DEPTH): sync-reset shift register. One instance, W=17 ({rd_en, addr_a, addr_b}),
//  DEPTH=D.
// TESTING
//  1 NTT, start at t0 -> rd_en first at t0+1, addrs (0,128), tw 1; i=1 -> (1,129); done at t0+939; exactly 896 wr_en.
//  2 NTT layer lg=1: i=0..3 -> (0,2)/(1,3)/(4,6)/(5,7), tw 64,64,65,65; last i=127 -> (253,255), tw 127.
//  3 INTT: first issue (0,2) tw 127; i=2 -> (4,6) tw 126; final layer (0,128) tw 1; bf_mode 01 throughout.
//  4 Hazard: every wr_addr at cycle t equals rd_addr D cycles earlier; no read in a layer precedes the last
//    write of the previous layer.
//  5 start pulsed while busy at t0+300 with inv flipped -> ignored, bf_mode unchanged, done still at t0+939.
//  6 rst at t0+200 -> next cycle all outputs at reset values, no wr_en afterwards; a new start runs to a full 939-cycle done.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants, butterfly modes, sequencer state type and the address/twiddle
// arithmetic for walking the Kyber NTT/INTT layers over a 256-coefficient bank.
package ntt_pkg;

  localparam int N      = 256;
  localparam int ADDR_W = 8;
  localparam int TW_W   = 7;
  localparam int NLAYER = 7;
  localparam int BF_W   = 7;

  localparam logic [1:0] MODE_NTT  = 2'b00;
  localparam logic [1:0] MODE_INTT = 2'b01;
  localparam logic [1:0] MODE_IDLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

  // Forward walks len 128..2 (lg 7..1), inverse walks len 2..128 (lg 1..7).
  function automatic logic [2:0] layer_lg(input logic [2:0] layer, input logic inv);
    return inv ? (layer + 3'd1) : (3'd7 - layer);
  endfunction

  // j = block*2*len + off, rewritten as i + block*len since i = block*len + off.
  function automatic logic [ADDR_W-1:0] bf_addr_a(input logic [BF_W-1:0] i, input logic [2:0] lg);
    logic [BF_W-1:0] blk;
    blk = i >> lg;
    return {1'b0, i} + ({1'b0, blk} << lg);
  endfunction

  // 2^(8-lg)-1 is formed as 7'h7F >> (lg-1) so the value never needs an eighth bit.
  function automatic logic [TW_W-1:0] bf_tw(input logic [BF_W-1:0] i, input logic [2:0] lg,
                                            input logic inv);
    logic [BF_W-1:0] blk;
    blk = i >> lg;
    if (inv) begin
      return (7'h7F >> (lg - 3'd1)) - blk;
    end
    return (7'd1 << (3'd7 - lg)) + blk;
  endfunction

endpackage

// File: rtl/ntt_delay_line.sv
// Synchronously cleared shift register; dout is din delayed exactly DEPTH cycles.
module ntt_delay_line
  import ntt_pkg::*;
#(
  parameter int W     = 17,
  parameter int DEPTH = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] pipe_q [DEPTH];
  logic [W-1:0] pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = din;
    for (int k = 1; k < DEPTH; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_seq_ctrl.sv
// Butterfly sequencer: one read pair per cycle across all seven layers, with the
// pipeline drained between layers so a layer never reads data still being written.
module ntt_seq_ctrl
  import ntt_pkg::*;
#(
  parameter int RAM_LAT = 1,
  parameter int BF_LAT  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              inv,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic [TW_W-1:0]   tw_idx,
  output logic [1:0]        bf_mode,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr_c,
  output logic [ADDR_W-1:0] wr_addr_d
);

  localparam int D   = RAM_LAT + BF_LAT;
  localparam int DW  = (D > 1) ? $clog2(D) : 1;
  localparam int DLW = 1 + 2 * ADDR_W;

  localparam logic [BF_W-1:0] BF_LAST    = BF_W'(N / 2 - 1);
  localparam logic [2:0]      LAYER_LAST = 3'(NLAYER - 1);
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(D - 1);

  seq_state_e        state_q, state_d;
  logic [BF_W-1:0]   bf_q, bf_d;
  logic [2:0]        layer_q, layer_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic              inv_q, inv_d;
  logic [2:0]        lg_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [ADDR_W-1:0] rd_addr_b_q, rd_addr_b_d;
  logic [TW_W-1:0]   tw_idx_q, tw_idx_d;
  logic [1:0]        bf_mode_q, bf_mode_d;

  logic [DLW-1:0]    wb_in, wb_out;

  always_comb begin
    state_d = state_q;
    bf_d    = bf_q;
    layer_d = layer_q;
    drain_d = drain_q;
    inv_d   = inv_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          bf_d    = '0;
          layer_d = '0;
          inv_d   = inv;
        end
      end
      ST_ISSUE: begin
        if (bf_q == BF_LAST) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else begin
          bf_d = bf_q + BF_W'(1);
        end
      end
      // D empty cycles let the last write of this layer land before the next read.
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          if (layer_q == LAYER_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            layer_d = layer_q + 3'd1;
            bf_d    = '0;
          end
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    lg_d        = layer_lg(layer_d, inv_d);
    rd_en_d     = (state_d == ST_ISSUE);
    busy_d      = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    done_d      = (state_d == ST_DONE);
    rd_addr_a_d = '0;
    rd_addr_b_d = '0;
    tw_idx_d    = '0;
    if (rd_en_d) begin
      rd_addr_a_d = bf_addr_a(bf_d, lg_d);
      rd_addr_b_d = rd_addr_a_d + (ADDR_W'(1) << lg_d);
      tw_idx_d    = bf_tw(bf_d, lg_d, inv_d);
    end
    bf_mode_d = busy_d ? (inv_d ? MODE_INTT : MODE_NTT) : MODE_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bf_q        <= '0;
      layer_q     <= '0;
      drain_q     <= '0;
      inv_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_idx_q    <= '0;
      bf_mode_q   <= MODE_IDLE;
    end else begin
      state_q     <= state_d;
      bf_q        <= bf_d;
      layer_q     <= layer_d;
      drain_q     <= drain_d;
      inv_q       <= inv_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      tw_idx_q    <= tw_idx_d;
      bf_mode_q   <= bf_mode_d;
    end
  end

  // Write-back strobe and addresses trail the reads by RAM plus butterfly latency.
  assign wb_in = {rd_en_q, rd_addr_a_q, rd_addr_b_q};

  ntt_delay_line #(
    .W     (DLW),
    .DEPTH (D)
  ) u_wb_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (wb_in),
    .dout (wb_out)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_addr_a_q;
  assign rd_addr_b = rd_addr_b_q;
  assign tw_idx    = tw_idx_q;
  assign bf_mode   = bf_mode_q;
  assign wr_en     = wb_out[DLW-1];
  assign wr_addr_c = wb_out[2*ADDR_W-1:ADDR_W];
  assign wr_addr_d = wb_out[ADDR_W-1:0];

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// Bench for ntt_seq_ctrl: per-cycle comparison against a timeline model of the
// layer walk, plus literal spot values and randomized start/inv/reset traffic.
module tb_ntt_seq_ctrl;

  localparam int RAM_LAT = 1;
  localparam int BF_LAT  = 5;
  localparam int D       = RAM_LAT + BF_LAT;
  localparam int P       = 128 + D;
  localparam int TOTAL   = 7 * P + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       inv;
  logic       busy, done, rd_en, wr_en;
  logic [7:0] rd_addr_a, rd_addr_b, wr_addr_c, wr_addr_d;
  logic [6:0] tw_idx;
  logic [1:0] bf_mode;

  always #5 clk = ~clk;

  ntt_seq_ctrl #(.RAM_LAT(RAM_LAT), .BF_LAT(BF_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .inv(inv),
    .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx), .bf_mode(bf_mode),
    .wr_en(wr_en), .wr_addr_c(wr_addr_c), .wr_addr_d(wr_addr_d)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int m_n = 0;
  bit m_inv = 1'b0;
  bit m_post_rst = 1'b0;
  bit chk_on = 1'b0;
  int wr_seen = 0;
  int last_wr = -100;
  bit prev_rd = 1'b0;

  int t2_a[4]  = '{0, 1, 4, 5};
  int t2_b[4]  = '{2, 3, 6, 7};
  int t2_tw[4] = '{64, 64, 65, 65};

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Read issued n cycles after start acceptance (n=1 is the first read).
  function automatic void model_rd(input int n, input bit iv, output bit en,
                                   output int a, output int b, output int tw);
    int layer, p, lg, len, blk, off;
    en = 1'b0; a = 0; b = 0; tw = 0;
    if (n < 1 || n > TOTAL - 1) return;
    layer = (n - 1) / P;
    p     = (n - 1) % P;
    if (layer > 6 || p > 127) return;
    lg  = iv ? layer + 1 : 7 - layer;
    len = 2 ** lg;
    blk = p / len;
    off = p % len;
    en  = 1'b1;
    a   = blk * 2 * len + off;
    b   = a + len;
    tw  = iv ? (2 ** (8 - lg) - 1 - blk) : (2 ** (7 - lg) + blk);
  endfunction

  // Model: m_n = cycles since accepted start, 0 when idle.
  always @(posedge clk) begin
    cyc++;
    m_post_rst = rst;
    if (rst) begin
      m_n = 0;
    end else if (m_n == 0) begin
      if (start) begin
        m_n = 1;
        m_inv = inv;
        wr_seen = 0;
      end
    end else if (m_n == TOTAL) begin
      m_n = 0;
    end else begin
      m_n++;
    end
  end

  always @(negedge clk) begin
    bit e_en, w_en, act_busy;
    int e_a, e_b, e_tw, w_a, w_b, w_tw;
    if (chk_on) begin
      model_rd(m_n, m_inv, e_en, e_a, e_b, e_tw);
      model_rd(m_n - D, m_inv, w_en, w_a, w_b, w_tw);
      act_busy = (m_n >= 1 && m_n <= TOTAL - 1);
      chk("busy", int'(busy), int'(act_busy));
      chk("done", int'(done), int'(m_n == TOTAL));
      chk("bf_mode", int'(bf_mode), act_busy ? int'(m_inv) : 3);
      chk("rd_en", int'(rd_en), int'(e_en));
      if (e_en) begin
        chk("rd_addr_a", int'(rd_addr_a), e_a);
        chk("rd_addr_b", int'(rd_addr_b), e_b);
        chk("tw_idx", int'(tw_idx), e_tw);
      end
      chk("wr_en", int'(wr_en), int'(w_en));
      if (w_en) begin
        chk("wr_addr_c", int'(wr_addr_c), w_a);
        chk("wr_addr_d", int'(wr_addr_d), w_b);
      end
      if (m_post_rst) begin
        chk("rst_addrs", int'(rd_addr_a) + int'(rd_addr_b) + int'(tw_idx)
                         + int'(wr_addr_c) + int'(wr_addr_d), 0);
      end
      if (rd_en && !prev_rd && m_n > 1) begin
        chk("raw_gap", cyc - last_wr, 1);
      end
      if (wr_en) begin
        wr_seen++;
        last_wr = cyc;
      end
      prev_rd = rd_en;
    end
  end

  task automatic step_to(inout int n, input int tgt, input bit noise);
    while (n < tgt) begin
      @(negedge clk);
      n++;
      if (noise && n < 930) begin
        start = ($urandom_range(0, 7) == 0);
        inv   = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic start_run(input bit iv, output int n);
    @(negedge clk);
    start = 1'b1;
    inv   = iv;
    @(negedge clk);
    start = 1'b0;
    n = 1;
  endtask

  task automatic wait_done(inout int n, output int done_at);
    int k;
    k = 0;
    while (!done && k < 1500) begin
      @(negedge clk);
      n++;
      k++;
      start = 1'b0;
    end
    done_at = done ? n : -1;
  endtask

  task automatic chk_rd(input string name, input int a, input int b, input int tw);
    chk({name, "_rd_en"}, int'(rd_en), 1);
    chk({name, "_a"}, int'(rd_addr_a), a);
    chk({name, "_b"}, int'(rd_addr_b), b);
    chk({name, "_tw"}, int'(tw_idx), tw);
  endtask

  initial begin
    int n;
    int done_at;
    int rn;
    rst = 1'b1; start = 1'b0; inv = 1'b0;
    @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_bf_mode", int'(bf_mode), 3);
    chk("reset_wr_en", int'(wr_en), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Forward NTT with literal spot values on first and last layers.
    start_run(1'b0, n);
    chk_rd("t1_i0", 0, 128, 1);
    chk("t1_mode", int'(bf_mode), 0);
    step_to(n, 2, 1'b0);
    chk_rd("t1_i1", 1, 129, 1);
    step_to(n, 805, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk_rd("t2_lg1", t2_a[i], t2_b[i], t2_tw[i]);
      step_to(n, n + 1, 1'b0);
    end
    step_to(n, 932, 1'b0);
    chk_rd("t2_last", 253, 255, 127);
    wait_done(n, done_at);
    chk("t1_done_at", done_at, 939);
    chk("t1_wr_count", wr_seen, 896);
    repeat (2) @(negedge clk);

    // Inverse NTT.
    start_run(1'b1, n);
    chk_rd("t3_i0", 0, 2, 127);
    chk("t3_mode", int'(bf_mode), 1);
    step_to(n, 3, 1'b0);
    chk_rd("t3_i2", 4, 6, 126);
    step_to(n, 805, 1'b0);
    chk_rd("t3_final", 0, 128, 1);
    chk("t3_mode_final", int'(bf_mode), 1);
    wait_done(n, done_at);
    chk("t3_done_at", done_at, 939);
    repeat (3) @(negedge clk);

    // start with flipped inv while busy must be ignored.
    start_run(1'b0, n);
    step_to(n, 300, 1'b0);
    start = 1'b1;
    inv   = 1'b1;
    step_to(n, 302, 1'b0);
    chk("t5_mode", int'(bf_mode), 0);
    wait_done(n, done_at);
    chk("t5_done_at", done_at, 939);
    repeat (2) @(negedge clk);

    // Reset mid-run (with start asserted alongside), then a clean full run.
    start_run(1'b1, n);
    step_to(n, 200, 1'b0);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("t6_busy", int'(busy), 0);
    chk("t6_rd_en", int'(rd_en), 0);
    chk("t6_wr_en", int'(wr_en), 0);
    chk("t6_bf_mode", int'(bf_mode), 3);
    chk("t6_rd_addr_a", int'(rd_addr_a), 0);
    rst   = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("t6_no_wr", int'(wr_en), 0);
    end
    start_run(1'b0, n);
    wait_done(n, done_at);
    chk("t6_done_at", done_at, 939);

    // Randomized runs with start/inv noise and one random reset.
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(1, 5)) @(negedge clk);
      start_run(1'($urandom_range(0, 1)), n);
      if (r == 2) begin
        rn = $urandom_range(10, 900);
        step_to(n, rn, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
      end else begin
        step_to(n, 930, 1'b1);
        wait_done(n, done_at);
        chk("rand_done_at", done_at, 939);
      end
    end
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
